// File: rtl/cuppa_regbank_if.sv
// Register bus bundle for cuppa_regbank: address, write data/strobe and
// the combinational read-data return path.
interface cuppa_regbank_if;
  logic [11:0] y_adr;
  logic [15:0] y_wr_data;
  logic        y_wr;
  logic [15:0] y_rd_data;

  modport master (output y_adr, output y_wr_data, output y_wr, input  y_rd_data);
  modport slave  (input  y_adr, input  y_wr_data, input  y_wr, output y_rd_data);
endinterface

// File: rtl/cuppa_regbank.sv
// Digitizer control register bank: per-channel trigger/waveform-buffer control,
// readout-buffer ownership and SPI task handshake. Optional lock: CUPPA_REGBANK_LOCK_EN.
module cuppa_regbank #(
  parameter int unsigned N_CHANNELS = 4,
  parameter int unsigned THR_WIDTH  = 12
) (
  input  logic                             clk,
  input  logic                             rst,
  cuppa_regbank_if.slave                   ybus,
  input  logic [15:0]                      vnum,
  output logic [5*N_CHANNELS-1:0]          trig_ctrl,
  output logic [THR_WIDTH*N_CHANNELS-1:0]  trig_thr,
  output logic [N_CHANNELS-1:0]            trig_run,
  output logic [N_CHANNELS-1:0]            wvb_arm,
  output logic [N_CHANNELS-1:0]            wvb_rst,
  input  logic [N_CHANNELS-1:0]            wvb_armed,
  input  logic [N_CHANNELS-1:0]            wvb_overflow,
  input  logic                             rdout_run,
  input  logic [15:0]                      rdout_len,
  input  logic [2:0]                       rdout_chan,
  output logic                             dpram_busy,
  output logic                             spi_req,
  input  logic                             spi_ack,
  output logic [23:0]                      spi_wr_data
);

  localparam int unsigned CTRL_W    = 5;
  localparam int unsigned RST_PULSE = 4;
  localparam int unsigned RST_CNT_W = $clog2(RST_PULSE);

  localparam logic [3:0]  OFF_CTRL   = 4'd0;
  localparam logic [3:0]  OFF_THR    = 4'd1;
  localparam logic [3:0]  OFF_ACTION = 4'd2;
  localparam logic [3:0]  OFF_RESET  = 4'd3;

  localparam logic [11:0] ADR_VNUM     = 12'hFFF;
  localparam logic [11:0] ADR_RD_BUSY  = 12'hFF0;
  localparam logic [11:0] ADR_RD_LEN   = 12'hFF1;
  localparam logic [11:0] ADR_RD_CHAN  = 12'hFF2;
  localparam logic [11:0] ADR_LOCK     = 12'hFF3;
  localparam logic [11:0] ADR_SPI_TASK = 12'hFE0;
  localparam logic [11:0] ADR_SPI_HI   = 12'hFE1;
  localparam logic [11:0] ADR_SPI_LO   = 12'hFE2;

  typedef enum logic {RD_IDLE, RD_BUSY}   rd_state_t;
  typedef enum logic {SPI_IDLE, SPI_BUSY} spi_state_t;

  logic [11:0] adr;
  logic [15:0] wdata;
  logic        wr;
  logic [3:0]  ch_idx;
  logic [3:0]  off;
  logic        ch_space;

  assign adr      = ybus.y_adr;
  assign wdata    = ybus.y_wr_data;
  assign wr       = ybus.y_wr;
  assign ch_idx   = adr[7:4];
  assign off      = adr[3:0];
  assign ch_space = (adr[11:8] == 4'hE);

  logic [CTRL_W-1:0]    ctrl_q  [N_CHANNELS];
  logic [THR_WIDTH-1:0] thr_q   [N_CHANNELS];
  logic [RST_CNT_W-1:0] rst_cnt [N_CHANNELS];

  rd_state_t   rd_state;
  spi_state_t  spi_state;
  logic [15:0] len_q;
  logic [2:0]  chan_q;

  logic [N_CHANNELS-1:0] wr_ch;
  logic [N_CHANNELS-1:0] wr_cfg;
  logic [N_CHANNELS-1:0] cfg_ok;

  // Channel write select; indices past N_CHANNELS never match, so those writes drop.
  always_comb begin
    wr_ch  = '0;
    wr_cfg = '0;
    for (int c = 0; c < N_CHANNELS; c++) begin
      wr_ch[c]  = wr && ch_space && (ch_idx == 4'(c));
      wr_cfg[c] = wr_ch[c] && ((off == OFF_CTRL) || (off == OFF_THR));
    end
  end

`ifdef CUPPA_REGBANK_LOCK_EN
  logic lock_q;
  logic viol_q;
  logic cfg_drop;

  assign cfg_ok   = lock_q ? ~wvb_armed : '1;
  assign cfg_drop = |(wr_cfg & ~cfg_ok);

  // Lock bit plus sticky violation flag; a new violation wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= 1'b0;
      viol_q <= 1'b0;
    end else begin
      if (wr && (adr == ADR_LOCK)) begin
        lock_q <= wdata[0];
        if (wdata[1]) viol_q <= 1'b0;
      end
      if (cfg_drop) viol_q <= 1'b1;
    end
  end
`else
  assign cfg_ok = '1;
`endif

  // Per-channel config, action pulses and timed buffer reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        ctrl_q[c]  <= '0;
        thr_q[c]   <= '0;
        rst_cnt[c] <= '0;
      end
      trig_run <= '0;
      wvb_arm  <= '0;
      wvb_rst  <= '0;
    end else begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        trig_run[c] <= wr_ch[c] && (off == OFF_ACTION) && wdata[0];
        wvb_arm[c]  <= wr_ch[c] && (off == OFF_ACTION) && wdata[1];
        if (wr_ch[c] && (off == OFF_CTRL) && cfg_ok[c]) ctrl_q[c] <= wdata[CTRL_W-1:0];
        if (wr_ch[c] && (off == OFF_THR)  && cfg_ok[c]) thr_q[c]  <= wdata[THR_WIDTH-1:0];
        // wvb_rst covers the write cycle's successor plus RST_PULSE-1 counted cycles.
        if (wr_ch[c] && (off == OFF_RESET) && wdata[0]) begin
          wvb_rst[c] <= 1'b1;
          rst_cnt[c] <= RST_CNT_W'(RST_PULSE - 1);
        end else if (rst_cnt[c] != '0) begin
          rst_cnt[c] <= rst_cnt[c] - RST_CNT_W'(1);
        end else begin
          wvb_rst[c] <= 1'b0;
        end
      end
    end
  end

  // Readout ownership and SPI task state machines.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state    <= RD_IDLE;
      len_q       <= '0;
      chan_q      <= '0;
      spi_state   <= SPI_IDLE;
      spi_wr_data <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: if (rdout_run) begin
          rd_state <= RD_BUSY;
          len_q    <= rdout_len;
          chan_q   <= rdout_chan;
        end
        RD_BUSY: if (wr && (adr == ADR_RD_BUSY) && wdata[0]) begin
          rd_state <= RD_IDLE;
          len_q    <= '0;
        end
        default: rd_state <= RD_IDLE;
      endcase

      case (spi_state)
        SPI_IDLE: if (wr && (adr == ADR_SPI_TASK) && wdata[0]) spi_state <= SPI_BUSY;
        SPI_BUSY: if (spi_ack) spi_state <= SPI_IDLE;
        default:  spi_state <= SPI_IDLE;
      endcase

      if (wr && (adr == ADR_SPI_HI)) spi_wr_data[23:16] <= wdata[7:0];
      if (wr && (adr == ADR_SPI_LO)) spi_wr_data[15:0]  <= wdata;
    end
  end

  assign dpram_busy = (rd_state == RD_BUSY);
  assign spi_req    = (spi_state == SPI_BUSY);

  always_comb begin
    trig_ctrl = '0;
    trig_thr  = '0;
    for (int c = 0; c < N_CHANNELS; c++) begin
      trig_ctrl[c*CTRL_W +: CTRL_W]       = ctrl_q[c];
      trig_thr[c*THR_WIDTH +: THR_WIDTH]  = thr_q[c];
    end
  end

  // Zero-latency read mux; anything unmapped returns zero.
  always_comb begin
    ybus.y_rd_data = '0;
    if (ch_space) begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        if (ch_idx == 4'(c)) begin
          case (off)
            OFF_CTRL:   ybus.y_rd_data = 16'(ctrl_q[c]);
            OFF_THR:    ybus.y_rd_data = 16'(thr_q[c]);
            OFF_ACTION: ybus.y_rd_data = {14'b0, wvb_overflow[c], wvb_armed[c]};
            OFF_RESET:  ybus.y_rd_data = {15'b0, wvb_rst[c]};
            default:    ybus.y_rd_data = '0;
          endcase
        end
      end
    end else begin
      case (adr)
        ADR_VNUM:     ybus.y_rd_data = vnum;
        ADR_RD_BUSY:  ybus.y_rd_data = {15'b0, dpram_busy};
        ADR_RD_LEN:   ybus.y_rd_data = len_q;
        ADR_RD_CHAN:  ybus.y_rd_data = {13'b0, chan_q};
        ADR_SPI_TASK: ybus.y_rd_data = {15'b0, spi_req};
        ADR_SPI_HI:   ybus.y_rd_data = {8'b0, spi_wr_data[23:16]};
        ADR_SPI_LO:   ybus.y_rd_data = spi_wr_data[15:0];
`ifdef CUPPA_REGBANK_LOCK_EN
        ADR_LOCK:     ybus.y_rd_data = {14'b0, viol_q, lock_q};
`endif
        default:      ybus.y_rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cuppa_regbank.sv
// Self-checking bench for cuppa_regbank: register vector table plus directed
// sequences for pulses, timed reset, readout, SPI handshake and reset override.
module tb_cuppa_regbank;
  localparam int unsigned N  = 4;
  localparam int unsigned TW = 12;

  logic              clk;
  logic              rst;
  logic [15:0]       vnum;
  logic [5*N-1:0]    trig_ctrl;
  logic [TW*N-1:0]   trig_thr;
  logic [N-1:0]      trig_run, wvb_arm, wvb_rst, wvb_armed, wvb_overflow;
  logic              rdout_run;
  logic [15:0]       rdout_len;
  logic [2:0]        rdout_chan;
  logic              dpram_busy, spi_req, spi_ack;
  logic [23:0]       spi_wr_data;

  cuppa_regbank_if ybus ();

  cuppa_regbank #(.N_CHANNELS(N), .THR_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .ybus(ybus), .vnum(vnum),
    .trig_ctrl(trig_ctrl), .trig_thr(trig_thr), .trig_run(trig_run),
    .wvb_arm(wvb_arm), .wvb_rst(wvb_rst), .wvb_armed(wvb_armed),
    .wvb_overflow(wvb_overflow), .rdout_run(rdout_run), .rdout_len(rdout_len),
    .rdout_chan(rdout_chan), .dpram_busy(dpram_busy), .spi_req(spi_req),
    .spi_ack(spi_ack), .spi_wr_data(spi_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        do_wr;
    logic [11:0] adr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr_reg(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    ybus.y_adr = a; ybus.y_wr_data = d; ybus.y_wr = 1'b1;
    @(negedge clk);
    ybus.y_wr = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [11:0] a, input logic [15:0] exp);
    ybus.y_adr = a; ybus.y_wr = 1'b0;
    #1;
    check(nm, 64'(ybus.y_rd_data), 64'(exp));
  endtask

  // Writes bit0 to a channel reset register, optionally rewrites on cycle `rewrite_at`,
  // and counts cycles with wvb_rst[ch] high over `span` samples.
  task automatic rst_pulse(input int ch, input int rewrite_at, input int span, output int ones);
    @(negedge clk);
    ybus.y_adr = 12'hE00 + 12'(16 * ch) + 12'h3; ybus.y_wr_data = 16'h0001; ybus.y_wr = 1'b1;
    ones = 0;
    for (int i = 1; i <= span; i++) begin
      @(negedge clk);
      ybus.y_wr = 1'b0;
      if (wvb_rst[ch]) ones++;
      if (i == 1) check("rst_reg_rd", 64'(ybus.y_rd_data), 64'h1);
      if (i == rewrite_at) ybus.y_wr = 1'b1;
    end
  endtask

  int ones;
  int cnt;
  bit done;

  initial begin
    vecs[0]  = '{1'b0, 12'hFFF, 16'h0000, 16'h1234};
    vecs[1]  = '{1'b1, 12'hE11, 16'h0ABC, 16'h0ABC};
    vecs[2]  = '{1'b1, 12'hE00, 16'h00FF, 16'h001F};
    vecs[3]  = '{1'b1, 12'hE31, 16'hF123, 16'h0123};
    vecs[4]  = '{1'b1, 12'hE41, 16'h0555, 16'h0000};
    vecs[5]  = '{1'b1, 12'hFFF, 16'h0000, 16'h1234};
    vecs[6]  = '{1'b0, 12'hE02, 16'h0000, 16'h0001};
    vecs[7]  = '{1'b0, 12'hE12, 16'h0000, 16'h0002};
    vecs[8]  = '{1'b0, 12'hE32, 16'h0000, 16'h0000};
    vecs[9]  = '{1'b1, 12'hFE1, 16'h00A5, 16'h00A5};
    vecs[10] = '{1'b1, 12'hFE2, 16'hBEEF, 16'hBEEF};
    vecs[11] = '{1'b0, 12'hE05, 16'h0000, 16'h0000};
    vecs[12] = '{1'b1, 12'hFF3, 16'h0002, 16'h0000};
    vecs[13] = '{1'b0, 12'h123, 16'h0000, 16'h0000};
    vecs[14] = '{1'b0, 12'hFF4, 16'h0000, 16'h0000};
    vecs[15] = '{1'b1, 12'hE21, 16'hFFFF, 16'h0FFF};
    vecs[16] = '{1'b0, 12'hFF0, 16'h0000, 16'h0000};
    vecs[17] = '{1'b0, 12'hFE0, 16'h0000, 16'h0000};
    vecs[18] = '{1'b1, 12'hE10, 16'h0015, 16'h0015};
    vecs[19] = '{1'b0, 12'hEF0, 16'h0000, 16'h0000};

    vnum = 16'h1234; wvb_armed = 4'b0101; wvb_overflow = 4'b0010;
    rdout_len = 16'h0000; rdout_chan = 3'd0; spi_ack = 1'b0;
    // Reset held against a competing write and readout start.
    rst = 1'b1; rdout_run = 1'b1;
    ybus.y_adr = 12'hE00; ybus.y_wr_data = 16'h001F; ybus.y_wr = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 64'(trig_ctrl), 64'h0);
    check("rst_busy", 64'(dpram_busy), 64'h0);
    check("rst_pulses", 64'({trig_run, wvb_arm, wvb_rst}), 64'h0);
    check("rst_spi", 64'({spi_req, spi_wr_data}), 64'h0);
    rst = 1'b0; rdout_run = 1'b0; ybus.y_wr = 1'b0;
    rd_chk("rst_e00_rd", 12'hE00, 16'h0000);

    // Threshold write appears exactly one edge later.
    @(negedge clk);
    ybus.y_adr = 12'hE11; ybus.y_wr_data = 16'h0ABC; ybus.y_wr = 1'b1;
    #1 check("thr_pre_edge", 64'(trig_thr[23:12]), 64'h0);
    @(negedge clk);
    ybus.y_wr = 1'b0;
    check("thr_post_edge", 64'(trig_thr[23:12]), 64'hABC);

    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].do_wr) wr_reg(vecs[i].adr, vecs[i].wdata);
      else @(negedge clk);
      rd_chk($sformatf("vec%0d", i), vecs[i].adr, vecs[i].exp_rd);
    end
    check("trig_thr_all", 64'(trig_thr), 64'h123FFFABC000);
    check("trig_ctrl_all", 64'(trig_ctrl), 64'h002BF);
    check("spi_wr_data", 64'(spi_wr_data), 64'hA5BEEF);

    // Action pulses.
    wr_reg(12'hE22, 16'h0003);
    check("act2_run", 64'(trig_run), 64'b0100);
    check("act2_arm", 64'(wvb_arm), 64'b0100);
    @(negedge clk);
    check("act2_done", 64'({trig_run, wvb_arm}), 64'h0);
    wr_reg(12'hE12, 16'h0001);
    check("act1_run_only", 64'({trig_run, wvb_arm}), 64'h20);
    wr_reg(12'hE42, 16'h0003);
    check("act4_none", 64'({trig_run, wvb_arm}), 64'h0);
    rd_chk("act4_rd", 12'hE42, 16'h0000);

    // Timed buffer reset: plain and restarted.
    rst_pulse(1, 0, 9, ones);
    check("wvb_rst1_len", 64'(ones), 64'd4);
    rst_pulse(0, 2, 10, ones);
    check("wvb_rst0_restart_len", 64'(ones), 64'd6);
    check("wvb_rst_idle", 64'(wvb_rst), 64'h0);

    // Readout ownership.
    @(negedge clk);
    rdout_len = 16'h0100; rdout_chan = 3'd1; rdout_run = 1'b1;
    @(negedge clk);
    rdout_run = 1'b0;
    check("rd_busy", 64'(dpram_busy), 64'h1);
    rd_chk("rd_ff0", 12'hFF0, 16'h0001);
    rd_chk("rd_ff1", 12'hFF1, 16'h0100);
    rd_chk("rd_ff2", 12'hFF2, 16'h0001);
    @(negedge clk);
    rdout_len = 16'h0005; rdout_chan = 3'd3; rdout_run = 1'b1;
    @(negedge clk);
    rdout_run = 1'b0;
    rd_chk("rd_ff1_hold", 12'hFF1, 16'h0100);
    rd_chk("rd_ff2_hold", 12'hFF2, 16'h0001);
    wr_reg(12'hFF0, 16'h0002);
    check("rd_busy_bit1", 64'(dpram_busy), 64'h1);
    wr_reg(12'hFF0, 16'h0001);
    check("rd_release", 64'(dpram_busy), 64'h0);
    rd_chk("rd_ff1_clr", 12'hFF1, 16'h0000);

    // SPI handshake: ack raised after seven request cycles, extra write mid-request.
    wr_reg(12'hFE0, 16'h0001);
    rd_chk("spi_req_rd", 12'hFE0, 16'h0001);
    cnt = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (spi_req) cnt++;
      ybus.y_wr = 1'b0;
      if (cnt == 3) begin ybus.y_adr = 12'hFE0; ybus.y_wr_data = 16'h0001; ybus.y_wr = 1'b1; end
      if (cnt == 7) spi_ack = 1'b1;
      @(negedge clk);
      if (spi_ack) begin spi_ack = 1'b0; done = 1'b1; end
    end
    ybus.y_wr = 1'b0;
    check("spi_req_cycles", 64'(cnt), 64'd7);
    check("spi_req_drop", 64'(spi_req), 64'h0);
    repeat (2) @(negedge clk);
    check("spi_no_retrigger", 64'(spi_req), 64'h0);

    // Reset mid-pulse and mid-handshake, with competing write and readout start.
    @(negedge clk);
    rdout_len = 16'h0042; rdout_chan = 3'd2; rdout_run = 1'b1;
    @(negedge clk);
    rdout_run = 1'b0;
    wr_reg(12'hFE0, 16'h0001);
    wr_reg(12'hE03, 16'h0001);
    check("pre_rst_active", 64'({dpram_busy, spi_req, wvb_rst[0]}), 64'h7);
    rst = 1'b1; rdout_run = 1'b1; rdout_len = 16'h0009;
    ybus.y_adr = 12'hE01; ybus.y_wr_data = 16'h0777; ybus.y_wr = 1'b1;
    @(negedge clk);
    check("mid_rst_thr", 64'(trig_thr), 64'h0);
    check("mid_rst_ctrl", 64'(trig_ctrl), 64'h0);
    check("mid_rst_pulses", 64'({trig_run, wvb_arm, wvb_rst}), 64'h0);
    check("mid_rst_fsm", 64'({dpram_busy, spi_req}), 64'h0);
    check("mid_rst_spi_data", 64'(spi_wr_data), 64'h0);
    rst = 1'b0; rdout_run = 1'b0; ybus.y_wr = 1'b0;
    ones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (wvb_rst[0]) ones++;
    end
    check("post_rst_no_pulse", 64'(ones), 64'd0);
    rd_chk("post_rst_ff1", 12'hFF1, 16'h0000);

`ifdef CUPPA_REGBANK_LOCK_EN
    wvb_armed = 4'b0001;
    wr_reg(12'hFF3, 16'h0001);
    wr_reg(12'hE01, 16'h0777);
    check("lock_thr0_kept", 64'(trig_thr[11:0]), 64'h0);
    rd_chk("lock_ff3_viol", 12'hFF3, 16'h0003);
    wr_reg(12'hE11, 16'h0333);
    check("lock_thr1_open", 64'(trig_thr[23:12]), 64'h333);
    wr_reg(12'hFF3, 16'h0003);
    rd_chk("lock_ff3_clr", 12'hFF3, 16'h0001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
